alu_ctrl_seq: RTL and testbench

- Multi-cycle control sequencer that drives the 16-bit `alu`. It fetches Hack-format instructions and issues the 6-bit ALU select word, consuming the ALU result and the zr/ng flags in return.
- Owns the A register, the D register and the PC. Evaluates jumps from zr/ng.
- Sequences instruction fetch, memory-operand read and memory write over valid/ready and ack handshakes.
- Sits between instruction ROM, data memory and the combinational `alu`.

---
 rtl/alu_ctrl_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
//
// Multi-cycle control sequencer for a Hack-style CPU built around an external
// combinational 16-bit ALU. The sequencer owns the A register, the D register
// and the program counter. Each instruction is fetched over a valid/ready
// handshake, decoded, optionally given a memory operand (M) through a read
// handshake, executed on the external ALU, and optionally written back to
// data memory through a write/ack handshake.
//
// Instruction formats (16 bits):
//   A-instruction : 0vvv_vvvv_vvvv_vvvv        A <= v, pc <= pc + 1
//   C-instruction : 1xxa_cccc_ccdd_djjj
//     a      (bit 12)    y operand is M (1) or A (0)
//     cccccc (bits 11:6) ALU select word
//     ddd    (bits 5:3)  destinations A, D, M
//     jjj    (bits 2:0)  jump on negative, zero, positive
//
// Ports:
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   pc                       instruction address
//   instr_valid/instr/
//   instr_ready              instruction fetch handshake
//   mem_addr                 data memory address (operand read or write)
//   mem_rd/mem_rvalid/
//   mem_rdata                memory operand read handshake
//   mem_we/mem_wdata/
//   mem_wack                 memory write handshake
//   alu_x, alu_y, alu_select operands and select word for the external ALU
//   alu_out, alu_zr, alu_ng  ALU result and flags
//   a_reg, d_reg             architectural A and D registers (debug view)
// ---------------------------------------------------------------------------
module alu_ctrl_seq #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // Instruction fetch
  output logic [width-1:0] pc,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  // Data memory
  output logic [width-1:0] mem_addr,
  output logic             mem_rd,
  input  logic             mem_rvalid,
  input  logic [width-1:0] mem_rdata,
  output logic             mem_we,
  output logic [width-1:0] mem_wdata,
  input  logic             mem_wack,
  // External ALU
  output logic [width-1:0] alu_x,
  output logic [width-1:0] alu_y,
  output logic [5:0]       alu_select,
  input  logic [width-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng,
  // Debug
  output logic [width-1:0] a_reg,
  output logic [width-1:0] d_reg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MREAD  = 3'd2,
    S_EXEC   = 3'd3,
    S_MWRITE = 3'd4
  } state_e;

  localparam logic [width-1:0] pc_step = width'(1);

  state_e           state;
  state_e           state_nxt;
  logic [15:0]      ir;
  logic [width-1:0] m_lat;

  // Instruction fields, named once so the datapath below reads as intent.
  logic       is_c_instr;
  logic       use_m;
  logic [5:0] comp;
  logic       dst_a;
  logic       dst_d;
  logic       dst_m;
  logic       jmp_lt;
  logic       jmp_eq;
  logic       jmp_gt;
  logic       jump_taken;
  logic       fetch_fire;

  assign is_c_instr = ir[15];
  assign use_m      = ir[12];
  assign comp       = ir[11:6];
  assign dst_a      = ir[5];
  assign dst_d      = ir[4];
  assign dst_m      = ir[3];
  assign jmp_lt     = ir[2];
  assign jmp_eq     = ir[1];
  assign jmp_gt     = ir[0];

  // Flags come straight from the ALU during EXEC, which is the only state in
  // which the jump decision is consumed.
  assign jump_taken = (jmp_lt & alu_ng) | (jmp_eq & alu_zr) |
                      (jmp_gt & ~alu_ng & ~alu_zr);

  // instr_ready is registered so it stays low for the whole reset period
  // and rises only once the sequencer has actually left reset.
  assign fetch_fire = instr_valid & instr_ready;

  // D is always the x operand; the debug ports expose the registers directly.
  assign alu_x = d_reg;

  // -------------------------------------------------------------------------
  // Next-state and ALU drive
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a value before the case so no
    // path through it leaves a signal unassigned, which would infer a latch.
    state_nxt  = state;
    alu_select = 6'b000000;
    alu_y      = a_reg;

    unique case (state)
      S_FETCH: begin
        if (fetch_fire) state_nxt = S_DECODE;
      end

      S_DECODE: begin
        if (!is_c_instr)  state_nxt = S_FETCH;
        else if (use_m)   state_nxt = S_MREAD;
        else              state_nxt = S_EXEC;
      end

      S_MREAD: begin
        if (mem_rvalid) state_nxt = S_EXEC;
      end

      S_EXEC: begin
        alu_select = comp;
        alu_y      = use_m ? m_lat : a_reg;
        state_nxt  = dst_m ? S_MWRITE : S_FETCH;
      end

      S_MWRITE: begin
        if (mem_wack) state_nxt = S_FETCH;
      end

      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register, handshake outputs and architectural state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here, datapath included, is reset so the debug
      // ports and memory interface show defined values straight out of reset.
      // An abandoned write is dropped immediately because mem_we is cleared
      // by the asynchronous reset, not on the next clock.
      state       <= S_FETCH;
      pc          <= '0;
      a_reg       <= '0;
      d_reg       <= '0;
      ir          <= '0;
      m_lat       <= '0;
      instr_ready <= 1'b0;
      mem_rd      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every right-hand side below read
      // the pre-edge value. That is what gives the old-A behaviour: the jump
      // target and write address use A as it was, even when A is also a
      // destination of the same instruction.
      state       <= state_nxt;
      instr_ready <= (state_nxt == S_FETCH);
      mem_rd      <= (state_nxt == S_MREAD);
      mem_we      <= (state_nxt == S_MWRITE);

      unique case (state)
        S_FETCH: begin
          if (fetch_fire) ir <= instr;
        end

        S_DECODE: begin
          if (!is_c_instr) begin
            a_reg <= width'(ir);
            pc    <= pc + pc_step;
          end else if (use_m) begin
            // The read address is A, stable for the whole read.
            mem_addr <= a_reg;
          end
        end

        S_MREAD: begin
          if (mem_rvalid) m_lat <= mem_rdata;
        end

        S_EXEC: begin
          if (dst_d) d_reg <= alu_out;
          if (dst_a) a_reg <= alu_out;
          if (dst_m) begin
            mem_addr  <= a_reg;
            mem_wdata <= alu_out;
          end
          // pc wraps silently at the top of the address space.
          pc <= jump_taken ? a_reg : pc + pc_step;
        end

        S_MWRITE: begin
          // Address and data are held until the write is acknowledged.
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_seq
//
// Scoreboard bench for alu_ctrl_seq. A directed Hack program sits in a small
// ROM model; the external ALU and data memory are modelled in the bench.
// The expected stream of observable events (instruction accepts with the
// architectural state at that moment, EXEC-cycle ALU drive, memory reads and
// writes) is written by hand into a queue; a monitor pops and compares each
// event when the DUT presents it.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_seq;

  localparam int W = 16;

  typedef enum int {EV_FETCH = 0, EV_EXEC = 1, EV_READ = 2, EV_WRITE = 3} ev_kind_e;

  typedef struct {
    ev_kind_e    kind;
    logic [15:0] v1;   // fetch: pc      exec: select  read/write: addr
    logic [15:0] v2;   // fetch: a_reg   exec: alu_y   write: wdata
    logic [15:0] v3;   // fetch: d_reg   exec: alu_x
    int          n;    // fetch: cycles since previous accept, rd/wr: strobe cycles (0 = skip)
  } ev_t;

  ev_t exp_q[$];
  int  rd_delays[$];
  int  wr_delays[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ev_idx = 0;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  pc;
  logic          instr_valid;
  logic [15:0]   instr;
  logic          instr_ready;
  logic [W-1:0]  mem_addr;
  logic          mem_rd;
  logic          mem_rvalid;
  logic [W-1:0]  mem_rdata;
  logic          mem_we;
  logic [W-1:0]  mem_wdata;
  logic          mem_wack;
  logic [W-1:0]  alu_x;
  logic [W-1:0]  alu_y;
  logic [5:0]    alu_select;
  logic [W-1:0]  alu_out;
  logic          alu_zr;
  logic          alu_ng;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  d_reg;

  alu_ctrl_seq #(.width(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_wack    (mem_wack),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_select  (alu_select),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .a_reg       (a_reg),
    .d_reg       (d_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Instruction ROM
  // -------------------------------------------------------------------------
  function automatic logic [15:0] rom_word(input logic [15:0] addr);
    case (addr)
      16'h0000: return 16'h0005;  // @5
      16'h0001: return 16'hE490;  // D=A
      16'h0002: return 16'h0064;  // @100
      16'h0003: return 16'hE188;  // M=D
      16'h0004: return 16'h000A;  // @10
      16'h0005: return 16'hE507;  // 0;JMP
      16'h000A: return 16'hE184;  // D;JLT  (D=5, not taken)
      16'h000B: return 16'h0020;  // @32
      16'h000C: return 16'hF490;  // D=M
      16'h000D: return 16'h0030;  // @48
      16'h000E: return 16'hE184;  // D;JLT  (D=0x8000, taken)
      16'h0030: return 16'h0040;  // @64
      16'h0031: return 16'hE522;  // A=0;JEQ (target is old A)
      16'h0040: return 16'h0050;  // @80
      16'h0041: return 16'hE1A8;  // AM=D   (address is old A)
      16'h0042: return 16'hEDA0;  // A=-1
      16'h0043: return 16'hE507;  // 0;JMP  to 0xFFFF
      16'hFFFF: return 16'h0003;  // @3, pc wraps to 0
      default:  return 16'h0000;
    endcase
  endfunction

  always_comb instr = rom_word(pc);

  // -------------------------------------------------------------------------
  // ALU model: x/y modes 00 pass, 01 zero, 10 invert, 11 all ones;
  // bit1 selects ADD over AND; bit0 inverts the result.
  // -------------------------------------------------------------------------
  function automatic logic [15:0] operand(input logic [1:0] mode, input logic [15:0] v);
    case (mode)
      2'b00:   return v;
      2'b01:   return 16'h0000;
      2'b10:   return ~v;
      default: return 16'hFFFF;
    endcase
  endfunction

  logic [15:0] alu_xo;
  logic [15:0] alu_yo;
  logic [15:0] alu_r;

  always_comb begin
    alu_xo = operand(alu_select[5:4], alu_x);
    alu_yo = operand(alu_select[3:2], alu_y);
    alu_r  = alu_select[1] ? (alu_xo + alu_yo) : (alu_xo & alu_yo);
    if (alu_select[0]) alu_r = ~alu_r;
    alu_out = alu_r;
    alu_zr  = (alu_r == 16'h0000);
    alu_ng  = alu_r[15];
  end

  // -------------------------------------------------------------------------
  // Data memory responder with per-transaction latencies
  // -------------------------------------------------------------------------
  int rd_w = 0;
  int wr_w = 0;
  int rd_lim = 0;
  int wr_lim = 0;

  initial begin
    mem_rvalid = 1'b0;
    mem_wack   = 1'b0;
    mem_rdata  = 16'h1234;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_wack   = 1'b0;
      mem_rdata  = 16'h1234;
      if (mem_rd) begin
        if (rd_w == 0) begin
          if (rd_delays.size() != 0) rd_lim = rd_delays.pop_front();
          else                       rd_lim = 0;
        end
        rd_w++;
        if (rd_w > rd_lim) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 16'h8000;
          rd_w       = 0;
        end
      end else begin
        rd_w = 0;
      end
      if (mem_we) begin
        if (wr_w == 0) begin
          if (wr_delays.size() != 0) wr_lim = wr_delays.pop_front();
          else                       wr_lim = 0;
        end
        wr_w++;
        if (wr_w > wr_lim) begin
          mem_wack = 1'b1;
          wr_w     = 0;
        end
      end else begin
        wr_w = 0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Checking helpers
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input logic [15:0] v1, input logic [15:0] v2,
                         input logic [15:0] v3, input int n);
    ev_t e;
    e.kind = k;
    e.v1   = v1;
    e.v2   = v2;
    e.v3   = v3;
    e.n    = n;
    exp_q.push_back(e);
  endtask

  task automatic exp_fetch(input logic [15:0] p, input logic [15:0] a, input logic [15:0] d, input int gap);
    push_ev(EV_FETCH, p, a, d, gap);
  endtask

  task automatic exp_exec(input logic [5:0] sel, input logic [15:0] y, input logic [15:0] x);
    push_ev(EV_EXEC, {10'b0, sel}, y, x, 0);
  endtask

  task automatic exp_read(input logic [15:0] addr, input int cyc);
    push_ev(EV_READ, addr, 16'h0, 16'h0, cyc);
  endtask

  task automatic exp_write(input logic [15:0] addr, input logic [15:0] data, input int cyc);
    push_ev(EV_WRITE, addr, data, 16'h0, cyc);
  endtask

  task automatic got(input ev_kind_e k, input logic [15:0] v1, input logic [15:0] v2,
                     input logic [15:0] v3, input int n);
    ev_t e;
    ev_idx++;
    check($sformatf("ev%0d_expected", ev_idx), (exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check($sformatf("ev%0d_kind", ev_idx), k, e.kind);
    if (k != e.kind) return;
    case (k)
      EV_FETCH: begin
        check($sformatf("ev%0d_fetch_pc", ev_idx), v1, e.v1);
        check($sformatf("ev%0d_fetch_a", ev_idx),  v2, e.v2);
        check($sformatf("ev%0d_fetch_d", ev_idx),  v3, e.v3);
        if (e.n != 0) check($sformatf("ev%0d_fetch_gap", ev_idx), n, e.n);
      end
      EV_EXEC: begin
        check($sformatf("ev%0d_exec_select", ev_idx), v1, e.v1);
        check($sformatf("ev%0d_exec_alu_y", ev_idx),  v2, e.v2);
        check($sformatf("ev%0d_exec_alu_x", ev_idx),  v3, e.v3);
      end
      EV_READ: begin
        check($sformatf("ev%0d_read_addr", ev_idx),   v1, e.v1);
        check($sformatf("ev%0d_read_cycles", ev_idx), n,  e.n);
      end
      default: begin
        check($sformatf("ev%0d_write_addr", ev_idx),   v1, e.v1);
        check($sformatf("ev%0d_write_data", ev_idx),   v2, e.v2);
        check($sformatf("ev%0d_write_cycles", ev_idx), n,  e.n);
      end
    endcase
  endtask

  // -------------------------------------------------------------------------
  // Monitor: samples on the falling edge, away from the active edge
  // -------------------------------------------------------------------------
  int   cyc = 0;
  int   last_fetch = 0;
  int   rd_cyc = 0;
  int   we_cyc = 0;
  logic rd_chk = 1'b0;
  logic we_chk = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_cyc = 0;
        we_cyc = 0;
        rd_chk = 1'b0;
        we_chk = 1'b0;
      end else begin
        cyc++;
        if (rd_chk) begin
          check("mem_rd_low_after_capture", mem_rd, 1'b0);
          rd_chk = 1'b0;
        end
        if (we_chk) begin
          check("mem_we_low_after_ack", mem_we, 1'b0);
          we_chk = 1'b0;
        end
        rd_cyc = mem_rd ? rd_cyc + 1 : 0;
        we_cyc = mem_we ? we_cyc + 1 : 0;
        if (instr_valid && instr_ready) begin
          got(EV_FETCH, pc, a_reg, d_reg, cyc - last_fetch);
          last_fetch = cyc;
        end
        if (alu_select != 6'b000000)
          got(EV_EXEC, {10'b0, alu_select}, alu_y, alu_x, 0);
        if (mem_rd && mem_rvalid) begin
          got(EV_READ, mem_addr, 16'h0, 16'h0, rd_cyc);
          rd_chk = 1'b1;
        end
        if (mem_we && mem_wack) begin
          got(EV_WRITE, mem_addr, mem_wdata, 16'h0, we_cyc);
          we_chk = 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int n_fetch;
  int budget;

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;

    wr_delays.push_back(3);    // M=D at pc 3: ack after 3 low cycles
    wr_delays.push_back(0);    // AM=D at pc 0x41: immediate ack
    wr_delays.push_back(100);  // second pass M=D: never acked, reset aborts it
    rd_delays.push_back(2);    // D=M at pc 0xC: rvalid 2 cycles late

    // Hand-derived event stream for the program in rom_word().
    exp_fetch(16'h0000, 16'h0000, 16'h0000, 0);
    exp_fetch(16'h0001, 16'h0005, 16'h0000, 2);
    exp_exec (6'h12,    16'h0005, 16'h0000);
    exp_fetch(16'h0002, 16'h0005, 16'h0005, 3);
    exp_fetch(16'h0003, 16'h0064, 16'h0005, 2);
    exp_exec (6'h06,    16'h0064, 16'h0005);
    exp_write(16'h0064, 16'h0005, 4);
    exp_fetch(16'h0004, 16'h0064, 16'h0005, 7);
    exp_fetch(16'h0005, 16'h000A, 16'h0005, 2);
    exp_exec (6'h14,    16'h000A, 16'h0005);
    exp_fetch(16'h000A, 16'h000A, 16'h0005, 3);
    exp_exec (6'h06,    16'h000A, 16'h0005);
    exp_fetch(16'h000B, 16'h000A, 16'h0005, 3);
    exp_fetch(16'h000C, 16'h0020, 16'h0005, 2);
    exp_read (16'h0020, 3);
    exp_exec (6'h12,    16'h8000, 16'h0005);
    exp_fetch(16'h000D, 16'h0020, 16'h8000, 6);
    exp_fetch(16'h000E, 16'h0030, 16'h8000, 2);
    exp_exec (6'h06,    16'h0030, 16'h8000);
    exp_fetch(16'h0030, 16'h0030, 16'h8000, 3);
    exp_fetch(16'h0031, 16'h0040, 16'h8000, 2);
    exp_exec (6'h14,    16'h0040, 16'h8000);
    exp_fetch(16'h0040, 16'h0000, 16'h8000, 3);
    exp_fetch(16'h0041, 16'h0050, 16'h8000, 2);
    exp_exec (6'h06,    16'h0050, 16'h8000);
    exp_write(16'h0050, 16'h8000, 1);
    exp_fetch(16'h0042, 16'h8000, 16'h8000, 4);
    exp_exec (6'h36,    16'h8000, 16'h8000);
    exp_fetch(16'h0043, 16'hFFFF, 16'h8000, 3);
    exp_exec (6'h14,    16'hFFFF, 16'h8000);
    exp_fetch(16'hFFFF, 16'hFFFF, 16'h8000, 3);
    exp_fetch(16'h0000, 16'h0003, 16'h8000, 2);
    exp_fetch(16'h0001, 16'h0005, 16'h8000, 2);
    exp_exec (6'h12,    16'h0005, 16'h8000);
    exp_fetch(16'h0002, 16'h0005, 16'h0005, 3);
    exp_fetch(16'h0003, 16'h0064, 16'h0005, 2);
    exp_exec (6'h06,    16'h0064, 16'h0005);

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pc",          pc,          16'h0000);
    check("rst_a_reg",       a_reg,       16'h0000);
    check("rst_d_reg",       d_reg,       16'h0000);
    check("rst_mem_we",      mem_we,      1'b0);
    check("rst_mem_rd",      mem_rd,      1'b0);
    check("rst_instr_ready", instr_ready, 1'b0);
    check("rst_mem_addr",    mem_addr,    16'h0000);
    check("rst_alu_select",  alu_select,  6'b000000);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_first_cycle", instr_ready, 1'b1);
    instr_valid = 1'b1;

    // Run the program until 22 instructions have been accepted.
    n_fetch = 0;
    budget  = 0;
    while (n_fetch < 22 && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (instr_valid && instr_ready) n_fetch++;
    end
    check("fetch_count_in_budget", n_fetch, 22);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;

    // Last accepted instruction is M=D with a write that is never acked.
    budget = 0;
    while (!mem_we && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("mwrite_entered", mem_we, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mem_we_async",  mem_we,      1'b0);
    check("abort_pc",            pc,          16'h0000);
    check("abort_a_reg",         a_reg,       16'h0000);
    check("abort_d_reg",         d_reg,       16'h0000);
    check("abort_instr_ready",   instr_ready, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_abort_ready", instr_ready, 1'b1);
    check("post_abort_pc",    pc,          16'h0000);
    check("post_abort_we",    mem_we,      1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("post_abort_idle_ready", instr_ready, 1'b1);

    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
